// File: rtl/sm_input_pkg.sv
// Shared definitions for the input debounce controller: per-channel
// stability FSM encoding and small elaboration-time helpers.
package sm_input_pkg;

    // Per-channel stability states. The low bit distinguishes "qualifying a
    // change" from "settled"; the debounced level is 1 in STABLE_HI/WAIT_LO.
    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_WAIT_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_WAIT_LO   = 2'd3
    } state_t;

    // Debounced level presented while the FSM sits in a given state.
    function automatic logic state_level(input state_t s);
        return (s == ST_STABLE_HI) || (s == ST_WAIT_LO);
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sm_debouncer.sv
// Two-flop synchroniser bringing the raw asynchronous pins into the clk
// domain. The debounced result lags the pins by two clock cycles.
module sm_debouncer #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] ds
);

    logic [SIZE-1:0] sync1_reg;
    logic [SIZE-1:0] sync2_reg;

    // Metastability chain: first stage captures the pin, second stage is used.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= d;
            sync2_reg <= sync1_reg;
        end
    end

    assign ds = sync2_reg;

endmodule

// File: rtl/sm_input_ctrl.sv
// Debounce controller for slow external inputs. Synchronised pins are
// sampled on a shared prescaler tick by a per-channel stability FSM, which
// yields a clean level, one-cycle edge pulses, sticky W1C event flags and a
// maskable registered interrupt.
module sm_input_ctrl
    import sm_input_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int PRESCALE     = 1000,
    parameter int STABLE_TICKS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] d,
    input  logic            en,
    input  logic [SIZE-1:0] irq_mask,
    input  logic [SIZE-1:0] evt_clr,
    output logic [SIZE-1:0] level,
    output logic [SIZE-1:0] rise,
    output logic [SIZE-1:0] fall,
    output logic [SIZE-1:0] evt_rise,
    output logic [SIZE-1:0] evt_fall,
    output logic            irq
);

    localparam int PW = width_for(PRESCALE);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [SIZE-1:0] ds;
    logic [PW-1:0]   pcnt_reg;
    logic [PW-1:0]   pcnt_next;
    logic            tick;
    logic            irq_reg;
    logic            irq_next;

    sm_debouncer #(
        .SIZE (SIZE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .ds    (ds)
    );

    // Prescaler: free-running 0..PRESCALE-1 while enabled, tick on the last count.
    always_comb begin
        tick      = en && (pcnt_reg == PCNT_LAST);
        pcnt_next = pcnt_reg;
        if (en) begin
            pcnt_next = tick ? '0 : pcnt_reg + 1'b1;
        end
    end

    // Prescaler register; frozen (not cleared) while en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_ch
            state_t        state_reg;
            state_t        state_next;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          level_reg;
            logic          level_next;
            logic          rise_reg;
            logic          fall_reg;
            logic          evt_rise_reg;
            logic          evt_fall_reg;

            // Stability FSM: count consecutive ticks at the opposite level, drop back on a glitch.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                if (tick) begin
                    case (state_reg)
                        ST_STABLE_LO: begin
                            if (ds[gi]) begin
                                if (STABLE_TICKS == 1) begin
                                    state_next = ST_STABLE_HI;
                                    cnt_next   = '0;
                                end else begin
                                    state_next = ST_WAIT_HI;
                                    cnt_next   = CNT_ONE;
                                end
                            end
                        end
                        ST_WAIT_HI: begin
                            if (ds[gi]) begin
                                if (cnt_reg == CNT_LAST) begin
                                    state_next = ST_STABLE_HI;
                                    cnt_next   = '0;
                                end else begin
                                    cnt_next = cnt_reg + 1'b1;
                                end
                            end else begin
                                state_next = ST_STABLE_LO;
                                cnt_next   = '0;
                            end
                        end
                        ST_STABLE_HI: begin
                            if (!ds[gi]) begin
                                if (STABLE_TICKS == 1) begin
                                    state_next = ST_STABLE_LO;
                                    cnt_next   = '0;
                                end else begin
                                    state_next = ST_WAIT_LO;
                                    cnt_next   = CNT_ONE;
                                end
                            end
                        end
                        ST_WAIT_LO: begin
                            if (!ds[gi]) begin
                                if (cnt_reg == CNT_LAST) begin
                                    state_next = ST_STABLE_LO;
                                    cnt_next   = '0;
                                end else begin
                                    cnt_next = cnt_reg + 1'b1;
                                end
                            end else begin
                                state_next = ST_STABLE_HI;
                                cnt_next   = '0;
                            end
                        end
                        default: begin
                            state_next = ST_STABLE_LO;
                            cnt_next   = '0;
                        end
                    endcase
                end
                level_next = state_level(state_next);
            end

            // State, level and edge pulses move together so rise/fall coincide with the level change.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg <= ST_STABLE_LO;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    level_reg <= level_next;
                    rise_reg  <= level_next & ~level_reg;
                    fall_reg  <= ~level_next & level_reg;
                end
            end

            // Sticky event flags: a pulse sets, evt_clr clears, set beats a simultaneous clear.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    evt_rise_reg <= 1'b0;
                    evt_fall_reg <= 1'b0;
                end else begin
                    evt_rise_reg <= (evt_rise_reg & ~evt_clr[gi]) | rise_reg;
                    evt_fall_reg <= (evt_fall_reg & ~evt_clr[gi]) | fall_reg;
                end
            end

            assign level[gi]    = level_reg;
            assign rise[gi]     = rise_reg;
            assign fall[gi]     = fall_reg;
            assign evt_rise[gi] = evt_rise_reg;
            assign evt_fall[gi] = evt_fall_reg;
        end
    endgenerate

    // Interrupt: any pending, unmasked event flag.
    always_comb begin
        irq_next = |((evt_rise | evt_fall) & irq_mask);
    end

    // Interrupt register, one cycle behind flag or mask changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_next;
        end
    end

    assign irq = irq_reg;

endmodule

// File: tb/tb_sm_input_ctrl.sv
// Self-checking bench for sm_input_ctrl: directed sequences, a small vector
// table for irq/W1C behaviour, and randomized stimulus against a
// run-length reference model (level flips after ST consecutive disagreeing ticks).
module tb_sm_input_ctrl;

    localparam int SZ = 2;
    localparam int PS = 4;
    localparam int ST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (PRESCALE=4, STABLE_TICKS=3)
    logic          rst_n, en, irq;
    logic [SZ-1:0] d, irq_mask, evt_clr;
    logic [SZ-1:0] level, rise, fall, evt_rise, evt_fall;

    // Fast instance (PRESCALE=1, STABLE_TICKS=1)
    logic          rst_n_b, en_b, irq_b;
    logic [SZ-1:0] d_b, irq_mask_b, evt_clr_b;
    logic [SZ-1:0] level_b, rise_b, fall_b, evt_rise_b, evt_fall_b;

    sm_input_ctrl #(.SIZE(SZ), .PRESCALE(PS), .STABLE_TICKS(ST)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .irq_mask(irq_mask), .evt_clr(evt_clr),
        .level(level), .rise(rise), .fall(fall), .evt_rise(evt_rise), .evt_fall(evt_fall),
        .irq(irq)
    );

    sm_input_ctrl #(.SIZE(SZ), .PRESCALE(1), .STABLE_TICKS(1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .d(d_b), .en(en_b), .irq_mask(irq_mask_b),
        .evt_clr(evt_clr_b), .level(level_b), .rise(rise_b), .fall(fall_b),
        .evt_rise(evt_rise_b), .evt_fall(evt_fall_b), .irq(irq_b)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Reference model state
    logic [SZ-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_er, m_ef;
    logic          m_irq;
    int            m_pc;
    int            m_run [SZ];

    typedef struct {
        logic [1:0] mask;
        logic [1:0] clr;
        logic       irq;
        logic [1:0] ef;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, req);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [SZ-1:0] nl, nr, nf;
        bit tick;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
            m_er = '0; m_ef = '0; m_irq = 1'b0; m_pc = 0;
            for (int i = 0; i < SZ; i++) m_run[i] = 0;
            return;
        end
        tick = en && (m_pc == PS - 1);
        nl = m_lvl; nr = '0; nf = '0;
        for (int ch = 0; ch < SZ; ch++) begin
            if (tick) begin
                if (m_s2[ch] != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == ST) begin
                        nl[ch] = ~m_lvl[ch];
                        m_run[ch] = 0;
                        if (nl[ch]) nr[ch] = 1'b1;
                        else        nf[ch] = 1'b1;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
        end
        if (en) m_pc = tick ? 0 : m_pc + 1;
        m_irq  = |((m_er | m_ef) & irq_mask);
        m_er   = (m_er & ~evt_clr) | m_rise;
        m_ef   = (m_ef & ~evt_clr) | m_fall;
        m_rise = nr;
        m_fall = nf;
        m_lvl  = nl;
        m_s2   = m_s1;
        m_s1   = d;
    endtask

    // One clock: step model, wait for the edge, sample 1 time unit later and compare.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        cycle++;
        check("model", 32'({level, rise, fall, evt_rise, evt_fall, irq}),
              32'({m_lvl, m_rise, m_fall, m_er, m_ef, m_irq}));
    endtask

    initial begin
        int  found, lat;
        bit  seen_a, seen_b;
        logic [SZ-1:0] lv;

        tbl[0] = '{2'b01, 2'b00, 1'b0, 2'b10};
        tbl[1] = '{2'b01, 2'b00, 1'b0, 2'b10};
        tbl[2] = '{2'b11, 2'b00, 1'b1, 2'b10};
        tbl[3] = '{2'b11, 2'b10, 1'b1, 2'b00};
        tbl[4] = '{2'b11, 2'b00, 1'b0, 2'b00};
        tbl[5] = '{2'b00, 2'b00, 1'b0, 2'b00};

        rst_n = 1'b0; en = 1'b1; d = 2'b11; irq_mask = '0; evt_clr = '0;
        rst_n_b = 1'b0; en_b = 1'b1; d_b = 2'b00; irq_mask_b = '0; evt_clr_b = '0;

        // 1: reset with pins high, then qualify
        for (int i = 0; i < 5; i++) cyc();
        check("rst_outputs", 32'({level, rise, fall, evt_rise, evt_fall, irq}), 32'd0);
        check("rst_outputs_b", 32'({level_b, rise_b, fall_b, evt_rise_b, evt_fall_b, irq_b}), 32'd0);
        rst_n = 1'b1; rst_n_b = 1'b1;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (level == 2'b11) begin found = k; break; end
        end
        $display("reset release: level=11 after %0d clk", found);
        check("rst_qual_within_15", 32'(found >= 1 && found <= 15), 32'd1);
        check("rst_rise", 32'(rise), 32'h3);
        cyc();
        check("rst_rise_once", 32'(rise), 32'h0);
        check("rst_evt_rise", 32'(evt_rise), 32'h3);

        // 2: clean edge on channel 0
        d = 2'b00;
        found = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (level == 2'b00) begin found = k; break; end
        end
        check("both_fall_seen", 32'(found != 0), 32'd1);
        evt_clr = 2'b11; cyc(); evt_clr = 2'b00;
        d = 2'b01;
        lat = 0; seen_b = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (fall[0]) seen_b = 1'b1;
            if (level[0]) begin lat = k; break; end
        end
        $display("clean edge: level[0] rose after %0d clk", lat);
        check("edge_lat_11_to_15", 32'(lat >= 11 && lat <= 15), 32'd1);
        check("edge_rise0", 32'(rise[0]), 32'd1);
        cyc();
        check("edge_rise0_once", 32'(rise[0]), 32'd0);
        check("edge_no_fall0", 32'(seen_b | fall[0]), 32'd0);

        // 3: glitch on channel 0
        d = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (!level[0]) break;
        end
        check("glitch_pre_low", 32'(level[0]), 32'd0);
        evt_clr = 2'b11; cyc(); evt_clr = 2'b00;
        seen_a = 1'b0;
        d = 2'b01;
        for (int k = 0; k < 6; k++) begin cyc(); seen_a |= level[0] | rise[0]; end
        d = 2'b00;
        for (int k = 0; k < 20; k++) begin cyc(); seen_a |= level[0] | rise[0]; end
        $display("glitch: 6 clk pulse on d[0] applied");
        check("glitch_level_rise", 32'(seen_a), 32'd0);
        check("glitch_evt_rise0", 32'(evt_rise[0]), 32'd0);

        // 4: W1C race on channel 1
        d = 2'b10;
        seen_a = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (rise[1]) begin seen_a = 1'b1; break; end
        end
        check("w1c_rise1_seen", 32'(seen_a), 32'd1);
        evt_clr = 2'b10; cyc(); evt_clr = 2'b00;
        check("w1c_set_wins", 32'(evt_rise[1]), 32'd1);
        evt_clr = 2'b10; cyc(); evt_clr = 2'b00;
        check("w1c_clear", 32'(evt_rise[1]), 32'd0);
        $display("w1c: race and clear sequence applied");

        // 5: irq masking, table driven
        evt_clr = 2'b11; cyc(); evt_clr = 2'b00;
        d = 2'b00;
        seen_a = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (fall[1]) begin seen_a = 1'b1; break; end
        end
        check("irq_fall1_seen", 32'(seen_a), 32'd1);
        cyc();
        for (int i = 0; i < 6; i++) begin
            irq_mask = tbl[i].mask;
            evt_clr  = tbl[i].clr;
            cyc();
            $display("vec %0d: mask=%b clr=%b irq=%b evt_fall=%b", i, tbl[i].mask, tbl[i].clr, irq, evt_fall);
            check("tbl_irq", 32'(irq), 32'(tbl[i].irq));
            check("tbl_evt_fall", 32'(evt_fall), 32'(tbl[i].ef));
        end
        evt_clr = 2'b00;

        // 6a: en=0 freezes the level while pins toggle
        en = 1'b0;
        lv = level;
        seen_a = 1'b0;
        for (int k = 0; k < 20; k++) begin
            d = 2'($urandom);
            cyc();
            if (level !== lv) seen_a = 1'b1;
        end
        check("en0_level_held", 32'(seen_a), 32'd0);
        $display("en=0: 20 clk of pin toggling applied");
        en = 1'b1;

        // 6b: PRESCALE=1, STABLE_TICKS=1 -> exactly 3 clk latency
        d_b = 2'b01;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (level_b[0]) begin lat = k; break; end
        end
        $display("fast rise latency %0d clk", lat);
        check("fast_rise_lat", 32'(lat), 32'd3);
        check("fast_rise_pulse", 32'(rise_b), 32'h1);
        d_b = 2'b00;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (!level_b[0]) begin lat = k; break; end
        end
        $display("fast fall latency %0d clk", lat);
        check("fast_fall_lat", 32'(lat), 32'd3);
        check("fast_fall_pulse", 32'(fall_b), 32'h1);

        // 7: randomized stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            for (int ch = 0; ch < SZ; ch++) begin
                if ($urandom_range(29, 0) == 0) d[ch] = ~d[ch];
            end
            en      = ($urandom_range(15, 0) != 0);
            rst_n   = ($urandom_range(499, 0) != 0);
            evt_clr = ($urandom_range(7, 0) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(49, 0) == 0) irq_mask = 2'($urandom);
            cyc();
        end
        rst_n = 1'b1;
        $display("random: 3000 clk applied");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
